dest_writeback_unit: RTL
========================

DEST_WRITEBACK_UNIT -- requirements
Module: dest_writeback_unit

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 17'd0, giving the PC value loaded at reset.
REQ-002 The block SHALL have parameter ERR_CNT_W, default 8, giving the width of the error counter.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 ResetN  input  1  reset; asynchronous, active-low.
REQ-005 WriteValid  input  1  producer offers a write-back transaction.
REQ-006 WriteReady  output  1  block can accept a transaction this cycle.
REQ-007 WriteData  input  17  result value to store.
REQ-008 Destination  input  4  destination code: 0=Input1 reg, 1=Input2 reg, 2=Input3 reg, 3/4/5=constant slots (read-only), 6=PC, 7-15 unused.
REQ-009 Advance  input  1  increment PC this cycle.
REQ-010 ErrorClear  input  1  clear the error flag and error count.
REQ-011 Reg1, Reg2, Reg3  output  17 each  stored operand registers; these feed the operand-source selector.
REQ-012 PC  output  17  program counter register.
REQ-013 ErrorFlag  output  1  sticky flag: an illegal destination was written.
REQ-014 ErrorCount  output  ERR_CNT_W  saturating count of illegal writes.

Function
REQ-015 A transaction SHALL be accepted on a rising edge where WriteValid=1 and WriteReady=1; nothing else accepts a transaction.
REQ-016 The FSM SHALL have two states, IDLE and FLUSH; WriteReady SHALL be 1 in IDLE and 0 in FLUSH.
REQ-017 An accepted transaction with Destination 0, 1 or 2 SHALL load WriteData into Reg1, Reg2 or Reg3 respectively, visible the cycle after acceptance (latency 1), and SHALL leave the FSM in IDLE.
REQ-018 An accepted transaction with Destination 6 SHALL load WriteData into PC, visible next cycle, and SHALL move the FSM to FLUSH.
REQ-019 FLUSH SHALL last exactly one cycle and then return unconditionally to IDLE; PC SHALL NOT change during FLUSH, even if Advance=1.
REQ-020 An accepted transaction with Destination 3, 4, 5 or 7-15 SHALL modify no register, SHALL set ErrorFlag, and SHALL increment ErrorCount, saturating at all-ones.
REQ-021 In IDLE with Advance=1 and no PC load accepted, PC SHALL become PC+1 modulo 2^17; 17'h1FFFF SHALL wrap to 17'h00000.
REQ-022 When a PC load and Advance=1 occur in the same cycle, the load SHALL win and no increment SHALL be applied.
REQ-023 ErrorClear=1 SHALL zero ErrorFlag and ErrorCount next cycle; when it coincides with an illegal write, the clear SHALL win.
REQ-024 WriteReady SHALL be a registered function of the FSM state only, with no combinational path from WriteValid.
REQ-025 WriteData and Destination SHALL be ignored whenever no transaction is accepted.

Reset
REQ-026 ResetN=0 SHALL asynchronously force FSM=IDLE, Reg1=Reg2=Reg3=0, PC=PC_RESET, ErrorFlag=0 and ErrorCount=0, independent of Clock.
REQ-027 While ResetN=0, WriteReady SHALL be 1 (IDLE state), and any in-progress FLUSH SHALL be abandoned.
REQ-028 The first rising edge after ResetN is deasserted SHALL be a normal IDLE cycle.

Structure
REQ-029 A shared package SHALL hold the destination codes (DST_IN1=0 through DST_PC=6), the 17-bit data width constant, the constant values 17'd95, 17'd200 and all-ones, and the FSM state enum.
REQ-030 The block SHALL contain exactly one sub-module, sat_counter, a parameterised saturating counter with clear, used for ErrorCount.

Verification
REQ-031 After reset, write (Destination=1, WriteData=17'h00ABC) -> Reg2=17'h00ABC one cycle later; Reg1, Reg3 and PC unchanged.
REQ-032 Write (Destination=6, WriteData=17'h00100) with Advance=1 held -> PC=17'h00100, WriteReady=0 for exactly one cycle, then PC=17'h00101 on the following cycle.
REQ-033 With PC=17'h1FFFF and Advance=1 -> PC=17'h00000.
REQ-034 Three writes to Destination=4, then 300 writes to Destination=15 -> all registers unchanged, ErrorFlag=1, ErrorCount=255; then ErrorClear=1 -> both 0.
REQ-035 Assert ResetN=0 asynchronously during FLUSH with PC_RESET=17'h00010 -> PC=17'h00010 and WriteReady=1 immediately, before the next Clock edge.
REQ-036 Hold WriteValid=1 through FLUSH -> no write occurs during FLUSH; the held transaction is accepted on the first IDLE cycle after it.

Source files
------------

// File: rtl/dest_writeback_unit_pkg.sv
// Shared definitions for the destination write-back unit.
// Holds the data width, the destination code map, the read-only constant
// slot values, the FSM state type and a small destination-decode helper.
package dest_writeback_unit_pkg;

  localparam int DATA_W = 17;

  // Destination codes. Codes 3..5 address read-only constant slots and
  // 7..15 are unused; writing any of them is an error.
  localparam logic [3:0] DST_IN1    = 4'd0;
  localparam logic [3:0] DST_IN2    = 4'd1;
  localparam logic [3:0] DST_IN3    = 4'd2;
  localparam logic [3:0] DST_CONST0 = 4'd3;
  localparam logic [3:0] DST_CONST1 = 4'd4;
  localparam logic [3:0] DST_CONST2 = 4'd5;
  localparam logic [3:0] DST_PC     = 4'd6;

  // Values presented by the read-only constant slots.
  localparam logic [DATA_W-1:0] CONST_95   = 17'd95;
  localparam logic [DATA_W-1:0] CONST_200  = 17'd200;
  localparam logic [DATA_W-1:0] CONST_ONES = {DATA_W{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } wb_state_e;

  // A destination is writable only if it names an operand register or the PC.
  function automatic logic dest_is_legal(input logic [3:0] dest);
    return (dest == DST_IN1) || (dest == DST_IN2) ||
           (dest == DST_IN3) || (dest == DST_PC);
  endfunction

endpackage

// File: rtl/dest_writeback_unit_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, with a clear that
// takes priority over an increment in the same cycle.
// Ports: clk, rst_n (async active-low), clr, inc, cnt (current count).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dest_writeback_unit.sv
// dest_writeback_unit: stores write-back results into the three operand
// registers or the PC, advances the PC, and counts writes aimed at
// read-only or unused destinations.
// Ports:
//   Clock, ResetN            clock, async active-low reset
//   WriteValid/WriteReady    write-back handshake
//   WriteData, Destination   result value and destination code
//   Advance                  increment PC (IDLE only, loses to a PC load)
//   ErrorClear               zero ErrorFlag/ErrorCount (wins over an error)
//   Reg1..Reg3, PC           stored registers
//   ErrorFlag, ErrorCount    sticky error flag, saturating error count
//   DebugState               current FSM state
//
// Handshake: a transaction transfers on a rising Clock edge where both
// WriteValid and WriteReady are 1. WriteReady depends only on the state
// register, never on WriteValid; WriteData/Destination are don't-care
// unless a transfer happens. After a PC load the unit spends one FLUSH
// cycle with WriteReady=0, so a producer holding WriteValid simply waits.
import dest_writeback_unit_pkg::*;

module dest_writeback_unit #(
  parameter logic [16:0] PC_RESET  = 17'd0,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 WriteValid,
  output logic                 WriteReady,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic [3:0]           Destination,
  input  logic                 Advance,
  input  logic                 ErrorClear,
  output logic [DATA_W-1:0]    Reg1,
  output logic [DATA_W-1:0]    Reg2,
  output logic [DATA_W-1:0]    Reg3,
  output logic [DATA_W-1:0]    PC,
  output logic                 ErrorFlag,
  output logic [ERR_CNT_W-1:0] ErrorCount,
  output wb_state_e            DebugState
);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic [DATA_W-1:0] reg3_q, reg3_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              err_flag_q, err_flag_d;
  logic              accept;
  logic              illegal_wr;

  assign WriteReady = (state_q == ST_IDLE);
  assign accept     = WriteValid && WriteReady;
  assign illegal_wr = accept && !dest_is_legal(Destination);

  always_comb begin
    state_d    = ST_IDLE;  // FLUSH always returns to IDLE
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    reg3_d     = reg3_q;
    pc_d       = pc_q;
    err_flag_d = err_flag_q;

    // Increment first so that a PC load below overrides it.
    if ((state_q == ST_IDLE) && Advance) begin
      pc_d = pc_q + 17'd1;
    end

    if (accept) begin
      case (Destination)
        DST_IN1: reg1_d = WriteData;
        DST_IN2: reg2_d = WriteData;
        DST_IN3: reg3_d = WriteData;
        DST_PC: begin
          pc_d    = WriteData;
          state_d = ST_FLUSH;
        end
        default: ;
      endcase
    end

    if (ErrorClear) begin
      err_flag_d = 1'b0;
    end else if (illegal_wr) begin
      err_flag_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      reg1_q     <= '0;
      reg2_q     <= '0;
      reg3_q     <= '0;
      pc_q       <= PC_RESET;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      reg3_q     <= reg3_d;
      pc_q       <= pc_d;
      err_flag_q <= err_flag_d;
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (Clock),
    .rst_n(ResetN),
    .clr  (ErrorClear),
    .inc  (illegal_wr),
    .cnt  (ErrorCount)
  );

  assign Reg1       = reg1_q;
  assign Reg2       = reg2_q;
  assign Reg3       = reg3_q;
  assign PC         = pc_q;
  assign ErrorFlag  = err_flag_q;
  assign DebugState = state_q;

endmodule
